// File: rtl/psg_pkg.sv
// Shared constants and helpers for the SN76489-compatible sound generator.
package psg_pkg;

    localparam int CLK_DIV_DEFAULT = 128;

    // LFSR seed loaded at reset and on every noise-register write
    localparam logic [15:0] LFSR_SEED = 16'h8000;

    // Feedback taps for white noise
    localparam int WHITE_TAP_A = 0;
    localparam int WHITE_TAP_B = 3;

    // Noise counter reload values for noise_ctrl[1:0] = 0, 1, 2
    localparam logic [6:0] NOISE_RATE_16 = 7'h10;
    localparam logic [6:0] NOISE_RATE_32 = 7'h20;
    localparam logic [6:0] NOISE_RATE_64 = 7'h40;

    localparam logic [1:0] NOISE_CH = 2'd3;

    typedef enum logic [1:0] {
        REG_TONE  = 2'd0,
        REG_VOL   = 2'd1,
        REG_NOISE = 2'd2
    } reg_type_e;

    // Amplitude per attenuation step; 15 is silence
    localparam logic [15:0] VOL_LUT [16] = '{
        16'd8191, 16'd6506, 16'd5168, 16'd4105,
        16'd3261, 16'd2590, 16'd2057, 16'd1634,
        16'd1298, 16'd1031, 16'd819,  16'd651,
        16'd517,  16'd411,  16'd326,  16'd0
    };

    function automatic reg_type_e reg_type(input logic [1:0] ch, input logic vol);
        if (vol)
            return REG_VOL;
        else if (ch == NOISE_CH)
            return REG_NOISE;
        else
            return REG_TONE;
    endfunction

    // Rate select 3 never reaches the counter (noise follows ch2 instead)
    function automatic logic [6:0] noise_rate(input logic [1:0] sel);
        case (sel)
            2'd0:    return NOISE_RATE_16;
            2'd1:    return NOISE_RATE_32;
            default: return NOISE_RATE_64;
        endcase
    endfunction

endpackage

// File: rtl/psg_tone.sv
// One square-wave tone channel: 10-bit down-counter and toggle flop.
module psg_tone (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [9:0] period,
    output logic       out,
    output logic       toggled
);

    logic [9:0] cnt;
    logic       out_q;
    logic       reload;

    assign reload  = (cnt <= 10'd1);
    assign toggled = tick && reload;
    // Periods 0 and 1 hold the output high so the CPU can play samples via attenuation
    assign out     = out_q | (period <= 10'd1);

    // Count down on each tick; reload and toggle at the bottom
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= 10'd0;
            out_q <= 1'b1;
        end else if (tick) begin
            if (reload) begin
                cnt   <= period;
                out_q <= ~out_q;
            end else begin
                cnt <= cnt - 10'd1;
            end
        end
    end

endmodule

// File: rtl/sms_psg.sv
// SN76489-compatible PSG: register file, three tone channels, noise channel, mixer.
module sms_psg
    import psg_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  io_wrdata,
    input  logic        io_wren,
    input  logic        next_sample,
    output logic [15:0] audio_out
);

    localparam int PW = $clog2(CLK_DIV);

    logic [PW-1:0] pre_cnt;
    logic          tick;

    logic [9:0]    period [3];
    logic [3:0]    atten  [4];
    logic [1:0]    latch_ch;
    logic          latch_vol;
    logic [2:0]    noise_ctrl;

    logic          wr_latch;
    logic [1:0]    wr_ch;
    logic          wr_vol;
    reg_type_e     wr_type;
    logic          noise_wr;

    logic [2:0]    tone_out;
    logic          tone2_toggled;
    logic [1:0]    toggled_unused;

    logic [6:0]    noise_cnt;
    logic          noise_tog;
    logic          noise_flip;
    logic          noise_shift;
    logic          noise_fb;
    logic [15:0]   lfsr;

    logic [15:0]   mix_sum;

    assign tick = (pre_cnt == PW'(CLK_DIV - 1));

    // Free-running prescaler producing one tick every CLK_DIV clocks
    always_ff @(posedge clk) begin
        if (reset)
            pre_cnt <= '0;
        else if (tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    // Decode which register the incoming byte targets
    always_comb begin
        wr_latch = io_wrdata[7];
        wr_ch    = wr_latch ? io_wrdata[6:5] : latch_ch;
        wr_vol   = wr_latch ? io_wrdata[4]   : latch_vol;
        wr_type  = reg_type(wr_ch, wr_vol);
        noise_wr = io_wren && (wr_type == REG_NOISE);
    end

    // Register file: latch, periods, attenuations, noise control
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) period[i] <= 10'd0;
            for (int i = 0; i < 4; i++) atten[i]  <= 4'hF;
            latch_ch   <= 2'd0;
            latch_vol  <= 1'b0;
            noise_ctrl <= 3'd0;
        end else if (io_wren) begin
            if (wr_latch) begin
                latch_ch  <= io_wrdata[6:5];
                latch_vol <= io_wrdata[4];
            end
            case (wr_type)
                REG_VOL:   atten[wr_ch] <= io_wrdata[3:0];
                REG_NOISE: noise_ctrl   <= io_wrdata[2:0];
                default: begin
                    for (int i = 0; i < 3; i++) begin
                        if (wr_ch == 2'(i)) begin
                            if (wr_latch)
                                period[i][3:0] <= io_wrdata[3:0];
                            else
                                period[i][9:4] <= io_wrdata[5:0];
                        end
                    end
                end
            endcase
        end
    end

    psg_tone u_tone0 (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .period  (period[0]),
        .out     (tone_out[0]),
        .toggled (toggled_unused[0])
    );

    psg_tone u_tone1 (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .period  (period[1]),
        .out     (tone_out[1]),
        .toggled (toggled_unused[1])
    );

    psg_tone u_tone2 (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .period  (period[2]),
        .out     (tone_out[2]),
        .toggled (tone2_toggled)
    );

    // Noise toggle source and LFSR feedback selection
    always_comb begin
        if (noise_ctrl[1:0] == 2'b11)
            noise_flip = tick && tone2_toggled;
        else
            noise_flip = tick && (noise_cnt <= 7'd1);
        noise_shift = noise_flip && !noise_tog;
        noise_fb    = noise_ctrl[2] ? (lfsr[WHITE_TAP_A] ^ lfsr[WHITE_TAP_B]) : lfsr[WHITE_TAP_A];
    end

    // Noise counter, toggle flop and LFSR; a register write beats a same-cycle shift
    always_ff @(posedge clk) begin
        if (reset) begin
            noise_cnt <= 7'd0;
            noise_tog <= 1'b1;
            lfsr      <= LFSR_SEED;
        end else begin
            if (tick && (noise_ctrl[1:0] != 2'b11)) begin
                if (noise_cnt <= 7'd1)
                    noise_cnt <= noise_rate(noise_ctrl[1:0]);
                else
                    noise_cnt <= noise_cnt - 7'd1;
            end
            if (noise_flip)
                noise_tog <= ~noise_tog;
            if (noise_wr)
                lfsr <= LFSR_SEED;
            else if (noise_shift)
                lfsr <= {noise_fb, lfsr[15:1]};
        end
    end

    // Sum the four gated channel amplitudes
    always_comb begin
        mix_sum = (tone_out[0] ? VOL_LUT[atten[0]] : 16'd0)
                + (tone_out[1] ? VOL_LUT[atten[1]] : 16'd0)
                + (tone_out[2] ? VOL_LUT[atten[2]] : 16'd0)
                + (lfsr[0]     ? VOL_LUT[atten[3]] : 16'd0);
    end

    // Output sample register, updated when the DAC accepts a sample
    always_ff @(posedge clk) begin
        if (reset)
            audio_out <= 16'h0000;
        else if (next_sample)
            audio_out <= mix_sum;
    end

endmodule
